umem_arbiter: RTL and testbench
===============================

# umem_arbiter

Shares one single-port unified instruction/data SRAM between the CPU's fetch stage (IF port) and memory stage (DM port). Each cycle it arbitrates between the two ports and drives the SRAM, then tracks the one outstanding read through a fixed read latency. It returns read data to the port that owns the read. A port that is not granted must hold its request; the pipeline uses the port's grant low as its stall condition.

## Interface
Parameters:
- ADDR_W, 16: word-address width of SRAM and both ports.
- MEM_LAT, 1: SRAM read latency in cycles, legal range 1..3.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch read request; held until granted.
- if_addr  input  ADDR_W  fetch word address.
- if_gnt  output  1  fetch request accepted this cycle.
- if_rvalid  output  1  one-cycle pulse; if_rdata valid.
- if_rdata  output  32  fetch read data.
- dm_req  input  1  data request (read or write); held until granted.
- dm_we  input  4  byte write enables; 4'b0000 = read.
- dm_addr  input  ADDR_W  data word address.
- dm_wdata  input  32  write data.
- dm_gnt  output  1  data request accepted this cycle.
- dm_rvalid  output  1  one-cycle pulse; dm_rdata valid (reads only).
- dm_rdata  output  32  data read data.
- mem_en  output  1  SRAM access strobe.
- mem_we  output  4  SRAM byte write enables.
- mem_addr  output  ADDR_W  SRAM address.
- mem_wdata  output  32  SRAM write data.
- mem_rdata  input  32  SRAM read data, valid MEM_LAT cycles after the mem_en cycle.
- busy  output  1  a read is outstanding (cnt != 0).

## Operation
State:
- 2-bit down-counter cnt: 0 = idle; nonzero = cycles remaining until read data returns.
- 1-bit owner: port that owns the outstanding read (0 = IF, 1 = DM).
- 1-bit last_dm: DM won the most recent contested grant.

Arbitration:
- Grants are allowed only when grant_ok = (cnt == 0) || (cnt == 1).
- At most one of if_gnt/dm_gnt is high per cycle. Grants are combinational from the requests, cnt and last_dm.
- Fixed priority: if dm_req, then dm_gnt; else if if_req, then if_gnt.

On the grant cycle:
- mem_en = 1; mem_addr/mem_we/mem_wdata come from the winning port. The IF port always drives mem_we = 0.
- With no grant: mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.

After the grant:
- Read grant (IF, or DM with dm_we == 0): cnt ← MEM_LAT, owner ← winner.
- DM write grant: write completes in the grant cycle; no rvalid; cnt ← 0 unless a read is still returning this cycle (cnt == 1, which decrements to 0 anyway).
- With no new read grant: if cnt != 0, cnt ← cnt − 1.

Read return:
- When cnt == 1, the owner's rvalid = 1 and its rdata = mem_rdata.
- Outside that cycle, rvalid = 0 and rdata = 0.

Reset (rst_n low):
- cnt = 0, owner = 0, last_dm = 0.
- All outputs 0: gnt, rvalid, rdata, mem_*, busy. Grants are forced 0 while rst_n is low.
- Reset mid-read discards the read; no rvalid follows. Requesters re-issue after reset.

## Timing
- Read grant at cycle T → rvalid at T+MEM_LAT.
- Back-to-back: a new grant is allowed in the rvalid cycle, so a read can be accepted every MEM_LAT cycles. With MEM_LAT = 1 that is one access per cycle.
- When cnt ≥ 2, both gnt outputs are 0 even if requests are asserted; busy = 1.
- Simultaneous rvalid and new grant in the same cycle: rvalid uses the old owner; owner is updated at the clock edge.
- Requests dropped before grant are legal and leave no side effect.

## Configuration
- UMEM_ARB_RR_EN defined: round-robin on contention. When both requests are asserted and grant_ok is true, grant DM if last_dm == 0, else IF. last_dm ← 1 on a contested DM win and ← 0 on a contested IF win. Uncontested grants leave last_dm unchanged.
- Undefined: fixed priority (DM over IF); last_dm is held at 0 and unused.

## Test plan
- Reset then idle: rst_n = 0 with if_req = 1 → all outputs 0. Release reset, MEM_LAT = 1, if_addr = 0x0010 → if_gnt = 1, mem_en = 1, mem_addr = 0x0010 same cycle; if_rvalid = 1 and if_rdata = mem_rdata (0xDEADBEEF) next cycle.
- Contention, fixed priority: if_req = dm_req = 1, dm_we = 0, MEM_LAT = 2 → dm_gnt at T. No grants at T+1 (busy = 1). dm_rvalid and if_gnt at T+2; if_rvalid at T+4.
- Write: dm_req = 1, dm_we = 4'b0011, dm_wdata = 0x12345678, addr 0x0004 → mem_we = 0011 in the grant cycle, no dm_rvalid. if_req granted the next cycle.
- Streaming, MEM_LAT = 1: if_req held for 4 cycles, addresses 0, 1, 2, 3 → if_gnt every cycle; rvalid in each following cycle with matching data.
- Reset mid-read: MEM_LAT = 3, read granted at T, rst_n low at T+1 → busy and rvalid drop immediately; no rvalid after release.
- UMEM_ARB_RR_EN: both ports requesting continuously, MEM_LAT = 1 → grants alternate DM, IF, DM, IF.

Source files
------------

// File: rtl/umem_arbiter.sv
// Arbiter sharing one single-port unified SRAM between the fetch (IF) and memory (DM) ports.
// Define UMEM_ARB_RR_EN for round-robin on contention; otherwise DM has fixed priority over IF.
module umem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic [3:0]        dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [31:0]       dm_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    localparam logic [1:0] LAT = 2'(MEM_LAT);

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;

    logic [1:0] cnt_q, cnt_d;
    logic       owner_q, owner_d;
    logic       grant_ok;
    logic       read_gnt;

`ifdef UMEM_ARB_RR_EN
    logic       last_dm_q, last_dm_d;
`endif

    assign grant_ok = (cnt_q == 2'd0) || (cnt_q == 2'd1);

    // Grants are gated by rst_n so nothing reaches the SRAM while reset is asserted.
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (grant_ok && rst_n) begin
`ifdef UMEM_ARB_RR_EN
            if (dm_req && if_req) begin
                dm_gnt = !last_dm_q;
                if_gnt = last_dm_q;
            end else if (dm_req) begin
                dm_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
`else
            if (dm_req) begin
                dm_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dm_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end
    end

    // Read data is steered to whichever port owned the read when cnt reaches 1.
    always_comb begin
        if_rvalid = 1'b0;
        dm_rvalid = 1'b0;
        if_rdata  = '0;
        dm_rdata  = '0;
        if (cnt_q == 2'd1) begin
            if (owner_q == OWNER_DM) begin
                dm_rvalid = 1'b1;
                dm_rdata  = mem_rdata;
            end else begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end
        end
    end

    assign busy     = (cnt_q != 2'd0);
    assign read_gnt = if_gnt || (dm_gnt && (dm_we == 4'b0000));

    // A write grant only happens with cnt at 0 or 1, so the plain decrement already lands on 0.
    always_comb begin
        cnt_d   = cnt_q;
        owner_d = owner_q;
        if (cnt_q != 2'd0) begin
            cnt_d = cnt_q - 2'd1;
        end
        if (read_gnt) begin
            cnt_d   = LAT;
            owner_d = dm_gnt ? OWNER_DM : OWNER_IF;
        end
    end

`ifdef UMEM_ARB_RR_EN
    always_comb begin
        last_dm_d = last_dm_q;
        if (dm_req && if_req && (dm_gnt || if_gnt)) begin
            last_dm_d = dm_gnt;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            owner_q <= OWNER_IF;
        end else begin
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end

`ifdef UMEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dm_q <= 1'b0;
        end else begin
            last_dm_q <= last_dm_d;
        end
    end
`endif

endmodule

// File: tb/tb_umem_arbiter.sv
// Directed bench for umem_arbiter: one instance per read latency (1, 2, 3) sharing stimulus,
// each with its own SRAM model whose data is a fixed function of the address.
module tb_umem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [15:0] if_addr;
    logic        dm_req;
    logic [3:0]  dm_we;
    logic [15:0] dm_addr;
    logic [31:0] dm_wdata;

    logic [3:1]  if_gnt_a, if_rvalid_a, dm_gnt_a, dm_rvalid_a, mem_en_a, busy_a;
    logic [31:0] if_rdata_a  [1:3];
    logic [31:0] dm_rdata_a  [1:3];
    logic [31:0] mem_wdata_a [1:3];
    logic [31:0] mem_rdata_a [1:3];
    logic [3:0]  mem_we_a    [1:3];
    logic [15:0] mem_addr_a  [1:3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] fdat(input logic [15:0] a);
        return 32'hDEADBEEF ^ {16'h0000, a ^ 16'h0010};
    endfunction

    for (genvar g = 1; g <= 3; g++) begin : g_dut
        logic [31:0] pipe [0:2];

        umem_arbiter #(.ADDR_W(16), .MEM_LAT(g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_gnt    (if_gnt_a[g]),
            .if_rvalid (if_rvalid_a[g]),
            .if_rdata  (if_rdata_a[g]),
            .dm_req    (dm_req),
            .dm_we     (dm_we),
            .dm_addr   (dm_addr),
            .dm_wdata  (dm_wdata),
            .dm_gnt    (dm_gnt_a[g]),
            .dm_rvalid (dm_rvalid_a[g]),
            .dm_rdata  (dm_rdata_a[g]),
            .mem_en    (mem_en_a[g]),
            .mem_we    (mem_we_a[g]),
            .mem_addr  (mem_addr_a[g]),
            .mem_wdata (mem_wdata_a[g]),
            .mem_rdata (mem_rdata_a[g]),
            .busy      (busy_a[g])
        );

        always @(posedge clk) begin
            pipe[0] <= fdat(mem_addr_a[g]);
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign mem_rdata_a[g] = pipe[g-1];
    end

    task automatic idle_inputs();
        if_req   = 1'b0;
        if_addr  = 16'h0000;
        dm_req   = 1'b0;
        dm_we    = 4'b0000;
        dm_addr  = 16'h0000;
        dm_wdata = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        idle_inputs();
        if_req = 1'b1;
        dm_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ((if_gnt_a | dm_gnt_a | mem_en_a | busy_a | if_rvalid_a | dm_rvalid_a) !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: gnt/en/busy/rvalid got %b%b%b%b%b%b expected all 0",
                     if_gnt_a, dm_gnt_a, mem_en_a, busy_a, if_rvalid_a, dm_rvalid_a);
        end
        checks++;
        if (mem_addr_a[1] !== 16'h0000 || mem_we_a[1] !== 4'h0 || if_rdata_a[1] !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_mem: addr=%h we=%h rdata=%h expected 0",
                     mem_addr_a[1], mem_we_a[1], if_rdata_a[1]);
        end
        next_cycle();
        rst_n   = 1'b1;
        dm_req  = 1'b0;
        if_addr = 16'h0010;
        @(negedge clk);
        checks++;
        if (if_gnt_a[1] !== 1'b1 || mem_en_a[1] !== 1'b1 || mem_addr_a[1] !== 16'h0010) begin
            errors++;
            $display("[TB] FAIL first_grant: gnt=%b en=%b addr=%h expected 1 1 0010",
                     if_gnt_a[1], mem_en_a[1], mem_addr_a[1]);
        end
        next_cycle();
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (if_rvalid_a[1] !== 1'b1 || if_rdata_a[1] !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL first_rvalid: rvalid=%b rdata=%h expected 1 deadbeef",
                     if_rvalid_a[1], if_rdata_a[1]);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (if_rvalid_a[1] !== 1'b0 || if_rdata_a[1] !== 32'h0 || busy_a[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_rvalid: rvalid=%b rdata=%h busy=%b expected 0 0 0",
                     if_rvalid_a[1], if_rdata_a[1], busy_a[1]);
        end
    endtask

    task automatic test_contention();
        do_reset();
        if_req  = 1'b1;
        if_addr = 16'h0020;
        dm_req  = 1'b1;
        dm_addr = 16'h0030;
        @(negedge clk);
        checks++;
        if (dm_gnt_a[2] !== 1'b1 || if_gnt_a[2] !== 1'b0 || mem_addr_a[2] !== 16'h0030) begin
            errors++;
            $display("[TB] FAIL contend_T: dm_gnt=%b if_gnt=%b addr=%h expected 1 0 0030",
                     dm_gnt_a[2], if_gnt_a[2], mem_addr_a[2]);
        end
        next_cycle();
        dm_req = 1'b0;
        @(negedge clk);
        checks++;
        if (if_gnt_a[2] !== 1'b0 || dm_gnt_a[2] !== 1'b0 || busy_a[2] !== 1'b1 || mem_en_a[2] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL contend_T1: if_gnt=%b dm_gnt=%b busy=%b en=%b expected 0 0 1 0",
                     if_gnt_a[2], dm_gnt_a[2], busy_a[2], mem_en_a[2]);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (dm_rvalid_a[2] !== 1'b1 || dm_rdata_a[2] !== fdat(16'h0030) || if_rvalid_a[2] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL contend_T2_rv: dm_rvalid=%b dm_rdata=%h if_rvalid=%b expected 1 %h 0",
                     dm_rvalid_a[2], dm_rdata_a[2], if_rvalid_a[2], fdat(16'h0030));
        end
        checks++;
        if (if_gnt_a[2] !== 1'b1 || mem_addr_a[2] !== 16'h0020) begin
            errors++;
            $display("[TB] FAIL contend_T2_gnt: if_gnt=%b addr=%h expected 1 0020",
                     if_gnt_a[2], mem_addr_a[2]);
        end
        next_cycle();
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (if_rvalid_a[2] !== 1'b0 || dm_rvalid_a[2] !== 1'b0 || busy_a[2] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL contend_T3: if_rvalid=%b dm_rvalid=%b busy=%b expected 0 0 1",
                     if_rvalid_a[2], dm_rvalid_a[2], busy_a[2]);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (if_rvalid_a[2] !== 1'b1 || if_rdata_a[2] !== fdat(16'h0020) || dm_rvalid_a[2] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL contend_T4: if_rvalid=%b if_rdata=%h dm_rvalid=%b expected 1 %h 0",
                     if_rvalid_a[2], if_rdata_a[2], dm_rvalid_a[2], fdat(16'h0020));
        end
    endtask

    task automatic test_write();
        do_reset();
        dm_req   = 1'b1;
        dm_we    = 4'b0011;
        dm_wdata = 32'h12345678;
        dm_addr  = 16'h0004;
        if_req   = 1'b1;
        if_addr  = 16'h0040;
        @(negedge clk);
        checks++;
        if (dm_gnt_a[1] !== 1'b1 || if_gnt_a[1] !== 1'b0 || mem_we_a[1] !== 4'b0011 ||
            mem_wdata_a[1] !== 32'h12345678 || mem_addr_a[1] !== 16'h0004) begin
            errors++;
            $display("[TB] FAIL write_grant: dm_gnt=%b if_gnt=%b we=%b wdata=%h addr=%h expected 1 0 0011 12345678 0004",
                     dm_gnt_a[1], if_gnt_a[1], mem_we_a[1], mem_wdata_a[1], mem_addr_a[1]);
        end
        next_cycle();
        dm_req = 1'b0;
        dm_we  = 4'b0000;
        @(negedge clk);
        checks++;
        if (if_gnt_a[1] !== 1'b1 || dm_rvalid_a[1] !== 1'b0 || mem_we_a[1] !== 4'b0000 ||
            mem_addr_a[1] !== 16'h0040) begin
            errors++;
            $display("[TB] FAIL write_next: if_gnt=%b dm_rvalid=%b we=%b addr=%h expected 1 0 0000 0040",
                     if_gnt_a[1], dm_rvalid_a[1], mem_we_a[1], mem_addr_a[1]);
        end
        next_cycle();
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (if_rvalid_a[1] !== 1'b1 || if_rdata_a[1] !== fdat(16'h0040) || dm_rvalid_a[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_if_read: if_rvalid=%b rdata=%h dm_rvalid=%b expected 1 %h 0",
                     if_rvalid_a[1], if_rdata_a[1], dm_rvalid_a[1], fdat(16'h0040));
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        if_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_addr = 16'(i);
            @(negedge clk);
            checks++;
            if (if_gnt_a[1] !== 1'b1 || mem_addr_a[1] !== 16'(i)) begin
                errors++;
                $display("[TB] FAIL stream_gnt[%0d]: gnt=%b addr=%h expected 1 %h",
                         i, if_gnt_a[1], mem_addr_a[1], 16'(i));
            end
            checks++;
            if (if_rvalid_a[1] !== (i > 0) || (i > 0 && if_rdata_a[1] !== fdat(16'(i - 1)))) begin
                errors++;
                $display("[TB] FAIL stream_rv[%0d]: rvalid=%b rdata=%h expected %b %h",
                         i, if_rvalid_a[1], if_rdata_a[1], (i > 0), fdat(16'(i - 1)));
            end
            next_cycle();
        end
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (if_rvalid_a[1] !== 1'b1 || if_rdata_a[1] !== fdat(16'h0003) || if_gnt_a[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stream_last: rvalid=%b rdata=%h gnt=%b expected 1 %h 0",
                     if_rvalid_a[1], if_rdata_a[1], if_gnt_a[1], fdat(16'h0003));
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        if_req  = 1'b1;
        if_addr = 16'h0055;
        @(negedge clk);
        checks++;
        if (if_gnt_a[3] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_grant: gnt=%b expected 1", if_gnt_a[3]);
        end
        next_cycle();
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_a[3] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_busy: busy=%b expected 1", busy_a[3]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_a[3] !== 1'b0 || if_rvalid_a[3] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_drop: busy=%b rvalid=%b expected 0 0", busy_a[3], if_rvalid_a[3]);
        end
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (if_rvalid_a[3] !== 1'b0 || dm_rvalid_a[3] !== 1'b0 || busy_a[3] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midrst_quiet[%0d]: if_rvalid=%b dm_rvalid=%b busy=%b expected 0 0 0",
                         i, if_rvalid_a[3], dm_rvalid_a[3], busy_a[3]);
            end
            next_cycle();
        end
    endtask

    task automatic test_arbitration_policy();
        logic [3:0] exp_dm;
`ifdef UMEM_ARB_RR_EN
        exp_dm = 4'b0101;
`else
        exp_dm = 4'b1111;
`endif
        do_reset();
        if_req  = 1'b1;
        dm_req  = 1'b1;
        if_addr = 16'h0100;
        dm_addr = 16'h0200;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (dm_gnt_a[1] !== exp_dm[i] || if_gnt_a[1] !== !exp_dm[i]) begin
                errors++;
                $display("[TB] FAIL policy[%0d]: dm_gnt=%b if_gnt=%b expected %b %b",
                         i, dm_gnt_a[1], if_gnt_a[1], exp_dm[i], !exp_dm[i]);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_contention();
        test_write();
        test_back_to_back();
        test_reset_mid_read();
        test_arbitration_policy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
